// File: rtl/fft_stream_ctrl.sv
// Frame sequencer for a streaming FFT pipeline: turns the enable-stalled
// datapath into valid/ready streams, tracks fill so stale contents are never
// emitted, drains the last frame with zero injection and labels each output
// sample with its frame position and natural-order bin.
module fft_stream_ctrl #(
    parameter int FFT_N    = 1024,
    parameter int PIPE_LAT = 1033,
    parameter int DATA_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic signed [DATA_W-1:0]   s_re,
    input  logic signed [DATA_W-1:0]   s_im,
    input  logic                       flush,
    output logic                       fft_enable,
    output logic [$clog2(FFT_N)-1:0]   fft_cnt,
    output logic signed [DATA_W-1:0]   fft_re,
    output logic signed [DATA_W-1:0]   fft_im,
    input  logic signed [DATA_W-1:0]   fft_res_re,
    input  logic signed [DATA_W-1:0]   fft_res_im,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic signed [DATA_W-1:0]   m_re,
    output logic signed [DATA_W-1:0]   m_im,
    output logic                       m_first,
    output logic                       m_last,
    output logic [$clog2(FFT_N)-1:0]   m_bin,
    output logic                       busy,
    output logic [15:0]                frame_cnt
);

    localparam int CW = $clog2(FFT_N);
    localparam int FW = $clog2(PIPE_LAT + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    localparam logic [FW-1:0] FILL_FULL  = FW'(PIPE_LAT);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(PIPE_LAT - 1);
    localparam logic [CW-1:0] IDX_LAST   = CW'(FFT_N - 1);

    logic [1:0]    r_state;
    logic [FW-1:0] r_fill;
    logic [FW-1:0] r_flush_cnt;
    logic [CW-1:0] r_fft_cnt;
    logic [CW-1:0] r_out_idx;
    logic [15:0]   r_frame_cnt;
    logic          r_flush_pend;

    logic w_in_flush;
    logic w_primed;
    logic w_flush_go;
    logic w_src_avail;
    logic w_go;
    logic w_adv;
    logic w_mvalid;
    logic w_xfer;
    logic w_flush_done;

    // Fill level saturates once the pipeline holds valid results.
    function automatic logic [FW-1:0] sat_inc_fill(input logic [FW-1:0] v);
        return (v == FILL_FULL) ? v : v + 1'b1;
    endfunction

    // Bit-reversed output index gives the natural-order bin number.
    function automatic logic [CW-1:0] bit_rev(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        for (int i = 0; i < CW; i++) begin
            r[i] = v[CW-1-i];
        end
        return r;
    endfunction

    assign w_in_flush  = (r_state == ST_FLUSH);
    assign w_primed    = (r_fill == FILL_FULL);
    // Frame boundary reached with a pending flush: the cycle is spent
    // switching to FLUSH, so neither side may transfer.
    assign w_flush_go  = (r_state == ST_RUN) & r_flush_pend & (r_fft_cnt == '0);
    assign w_src_avail = w_in_flush | s_valid;
    assign w_go        = (m_ready | ~w_primed) & ~w_flush_go;
    assign w_adv       = w_src_avail & w_go;
    assign w_mvalid    = w_src_avail & w_primed & ~w_flush_go;
    assign w_xfer      = w_mvalid & m_ready;
    assign w_flush_done = w_in_flush & w_adv & (r_flush_cnt == FLUSH_LAST);

    assign s_ready    = ~w_in_flush & w_go;
    assign fft_enable = w_adv & rst;
    assign fft_cnt    = r_fft_cnt;
    assign fft_re     = w_in_flush ? '0 : s_re;
    assign fft_im     = w_in_flush ? '0 : s_im;
    assign m_valid    = w_mvalid;
    assign m_re       = fft_res_re;
    assign m_im       = fft_res_im;
    assign m_first    = w_mvalid & (r_out_idx == '0);
    assign m_last     = w_mvalid & (r_out_idx == IDX_LAST);
    assign m_bin      = bit_rev(r_out_idx);
    assign busy       = (r_state != ST_IDLE);
    assign frame_cnt  = r_frame_cnt;

    // Sequencer state: start on first accepted sample, drain at a frame boundary.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (w_adv)        r_state <= ST_RUN;
                ST_RUN:   if (w_flush_go)   r_state <= ST_FLUSH;
                ST_FLUSH: if (w_flush_done) r_state <= ST_IDLE;
                default:                    r_state <= ST_IDLE;
            endcase
        end
    end

    // Flush request latch and zero-injection counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_flush_pend <= 1'b0;
            r_flush_cnt  <= '0;
        end else begin
            if (w_flush_done) begin
                r_flush_pend <= 1'b0;
            end else if (flush && (r_state != ST_IDLE)) begin
                r_flush_pend <= 1'b1;
            end
            if (w_flush_done) begin
                r_flush_cnt <= '0;
            end else if (w_in_flush && w_adv) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    // Advance-driven counters: sample index, fill level and output position.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fill    <= '0;
            r_fft_cnt <= '0;
            r_out_idx <= '0;
        end else if (w_flush_done) begin
            r_fill    <= '0;
            r_fft_cnt <= '0;
            r_out_idx <= '0;
        end else if (w_adv) begin
            r_fill    <= sat_inc_fill(r_fill);
            r_fft_cnt <= r_fft_cnt + 1'b1;
            if (w_mvalid) begin
                r_out_idx <= r_out_idx + 1'b1;
            end
        end
    end

    // Completed output frames survive the drain; only reset clears them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_frame_cnt <= '0;
        end else if (w_xfer && (r_out_idx == IDX_LAST)) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_fft_stream_ctrl.sv
// Bench for fft_stream_ctrl: a delay-line stand-in for the FFT datapath, a
// randomized valid/ready source and sink, and a transaction-level reference
// model (accepted-sample scoreboard plus advance/output counting).
module tb_fft_stream_ctrl;

    localparam int N   = 1024;
    localparam int LAT = 1033;
    localparam int DW  = 16;
    localparam int CW  = 10;

    logic clk = 1'b0;
    logic rst;
    logic s_valid, s_ready, flush, fft_enable, m_valid, m_ready;
    logic m_first, m_last, busy;
    logic signed [DW-1:0] s_re, s_im, fft_re, fft_im, m_re, m_im;
    logic signed [DW-1:0] fft_res_re = '0;
    logic signed [DW-1:0] fft_res_im = '0;
    logic [CW-1:0] fft_cnt, m_bin;
    logic [15:0]   frame_cnt;

    always #5 clk = ~clk;

    fft_stream_ctrl #(.FFT_N(N), .PIPE_LAT(LAT), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_re(s_re), .s_im(s_im),
        .flush(flush),
        .fft_enable(fft_enable), .fft_cnt(fft_cnt), .fft_re(fft_re), .fft_im(fft_im),
        .fft_res_re(fft_res_re), .fft_res_im(fft_res_im),
        .m_valid(m_valid), .m_ready(m_ready), .m_re(m_re), .m_im(m_im),
        .m_first(m_first), .m_last(m_last), .m_bin(m_bin),
        .busy(busy), .frame_cnt(frame_cnt)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int bitrev(input int v);
        int r;
        r = 0;
        for (int i = 0; i < CW; i++) r = (r << 1) | ((v >> i) & 1);
        return r;
    endfunction

    // Values captured at the falling edge, consumed at the next rising edge.
    logic en_q = 1'b0;
    logic hs_q = 1'b0;
    logic signed [DW-1:0] fre_q = '0;
    logic signed [DW-1:0] fim_q = '0;

    // FFT stand-in: a PIPE_LAT-deep delay line advanced by fft_enable.
    logic signed [DW-1:0] pipe_re[$];
    logic signed [DW-1:0] pipe_im[$];
    always @(posedge clk) begin
        if (pipe_re.size() == 0) begin
            for (int i = 0; i < LAT; i++) begin
                pipe_re.push_back(DW'($urandom));
                pipe_im.push_back(DW'($urandom));
            end
        end
        if (en_q) begin
            pipe_re.push_back(fre_q);
            pipe_im.push_back(fim_q);
            void'(pipe_re.pop_front());
            void'(pipe_im.pop_front());
        end
        fft_res_re <= pipe_re[0];
        fft_res_im <= pipe_im[0];
    end

    // Reference model state (written only by the monitor).
    logic signed [DW-1:0] exp_re[$];
    logic signed [DW-1:0] exp_im[$];
    int accepted = 0, adv_cnt = 0, flush_adv = 0, out_pos = 0, frames = 0;
    int acc_total = 0, out_total = 0, en_total = 0, idle_seen = 0, first_adv = 0;
    logic idle_chk = 1'b0;
    logic prev_stall = 1'b0;
    logic signed [DW-1:0] prev_re = '0;
    logic signed [DW-1:0] prev_im = '0;
    logic mon_on = 1'b0;

    // Monitor and reference model, evaluated away from the active edge.
    always @(negedge clk) begin
        logic hs, xf, en;
        int pos;
        en_q  = fft_enable;
        fre_q = fft_re;
        fim_q = fft_im;
        hs_q  = s_valid & s_ready;
        if (!rst) begin
            exp_re.delete();
            exp_im.delete();
            accepted = 0; adv_cnt = 0; flush_adv = 0; out_pos = 0; frames = 0;
            idle_chk = 1'b0; prev_stall = 1'b0;
        end else if (mon_on) begin
            hs = s_valid & s_ready;
            xf = m_valid & m_ready;
            en = fft_enable;
            if (idle_chk) begin
                check_eq("idle_after_drain", int'(busy), 0);
                idle_chk = 1'b0;
            end
            check_eq("fft_cnt", int'(fft_cnt), adv_cnt % N);
            check_eq("frame_cnt", int'(frame_cnt), frames);
            if (hs) begin
                check_eq("enable_on_accept", int'(en), 1);
                check_eq("fft_re_pass", int'(fft_re), int'(s_re));
                check_eq("fft_im_pass", int'(fft_im), int'(s_im));
            end
            if (en && !hs) begin
                if (flush_adv == 0) check_eq("flush_frame_align", accepted % N, 0);
                check_eq("fft_re_zero", int'(fft_re), 0);
                check_eq("fft_im_zero", int'(fft_im), 0);
            end
            if (en) check_eq("m_valid_vs_fill", int'(m_valid), int'(adv_cnt >= LAT));
            if (m_valid) check_eq("transfer_is_advance", int'(en), int'(m_ready));
            if (prev_stall && m_valid) begin
                check_eq("stall_re_stable", int'(m_re), int'(prev_re));
                check_eq("stall_im_stable", int'(m_im), int'(prev_im));
            end
            if (xf) begin
                check_eq("output_expected", int'(exp_re.size() > 0), 1);
                if (exp_re.size() > 0) begin
                    check_eq("m_re", int'(m_re), int'(exp_re.pop_front()));
                    check_eq("m_im", int'(m_im), int'(exp_im.pop_front()));
                end
                pos = out_pos % N;
                check_eq("m_first", int'(m_first), int'(pos == 0));
                check_eq("m_last", int'(m_last), int'(pos == N - 1));
                check_eq("m_bin", int'(m_bin), bitrev(pos));
                if (pos == 1) check_eq("m_bin_idx1", int'(m_bin), 512);
                if (pos == 2) check_eq("m_bin_idx2", int'(m_bin), 256);
                if (out_pos == 0) first_adv = adv_cnt + 1;
                out_pos++;
                out_total++;
                if (pos == N - 1) frames = (frames + 1) % 65536;
            end
            prev_stall = m_valid & ~m_ready;
            prev_re = m_re;
            prev_im = m_im;
            if (hs) begin
                exp_re.push_back(s_re);
                exp_im.push_back(s_im);
                accepted++;
                acc_total++;
            end
            if (en) begin
                adv_cnt++;
                en_total++;
                if (!hs) flush_adv++;
            end
            if (flush_adv == LAT) begin
                check_eq("drain_complete", exp_re.size(), 0);
                accepted = 0; adv_cnt = 0; flush_adv = 0; out_pos = 0;
                idle_chk = 1'b1;
                idle_seen++;
            end
        end
    end

    // Stimulus knobs.
    int vpct = 0, rpct = 100, offered = 0, src_limit = 0;
    logic stop_on_flush = 1'b0;

    task automatic drive_cycle();
        @(posedge clk);
        #1;
        if (hs_q) s_valid = 1'b0;
        if (stop_on_flush && flush_adv > 0) begin
            s_valid = 1'b0;
        end else if (!s_valid && offered < src_limit && int'($urandom_range(99)) < vpct) begin
            s_valid = 1'b1;
            s_re = DW'($urandom);
            s_im = DW'($urandom);
            offered++;
        end
        m_ready = (int'($urandom_range(99)) < rpct);
        flush = 1'b0;
    endtask

    task automatic wait_accept(input int target, input int budget, input string tag);
        for (int c = 0; c < budget && acc_total < target; c++) drive_cycle();
        check_eq(tag, int'(acc_total >= target), 1);
    endtask

    task automatic run_until_idle(input int budget, input string tag);
        int base;
        base = idle_seen;
        for (int c = 0; c < budget && idle_seen == base; c++) drive_cycle();
        check_eq(tag, idle_seen, base + 1);
        drive_cycle();
        drive_cycle();
    endtask

    int acc_base, out_base, en_base;
    logic flushed;

    initial begin
        s_valid = 1'b0; s_re = '0; s_im = '0; m_ready = 1'b0; flush = 1'b0;
        rst = 1'b1;
        #1 rst = 1'b0;

        // Reset held with toggling inputs.
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            s_valid = 1'($urandom_range(1));
            m_ready = 1'($urandom_range(1));
            flush   = 1'($urandom_range(1));
            s_re    = DW'($urandom);
            @(negedge clk);
            check_eq("rst_fft_enable", int'(fft_enable), 0);
            check_eq("rst_m_valid", int'(m_valid), 0);
            check_eq("rst_s_ready", int'(s_ready), 1);
            check_eq("rst_busy", int'(busy), 0);
            check_eq("rst_fft_cnt", int'(fft_cnt), 0);
            check_eq("rst_frame_cnt", int'(frame_cnt), 0);
        end
        s_valid = 1'b0; flush = 1'b0; m_ready = 1'b1;
        @(posedge clk);
        #1 rst = 1'b1;
        mon_on = 1'b1;

        // Two frames at full rate, flush afterwards.
        vpct = 100; rpct = 100;
        acc_base = acc_total; out_base = out_total; en_base = en_total;
        src_limit = offered + 2 * N;
        wait_accept(acc_base + 2 * N, 5000, "B_accept_timeout");
        for (int i = 0; i < 10; i++) drive_cycle();
        drive_cycle();
        flush = 1'b1;
        run_until_idle(5000, "B_drain_timeout");
        check_eq("B_enable_cycles", en_total - en_base, 2 * N + LAT);
        check_eq("B_outputs", out_total - out_base, 2 * N);
        check_eq("B_first_out_advance", first_adv, LAT + 1);
        check_eq("B_frame_cnt", int'(frame_cnt), 2);
        check_eq("B_busy", int'(busy), 0);

        // Random backpressure; flush requested mid frame 3.
        vpct = 70; rpct = 50; stop_on_flush = 1'b1;
        acc_base = acc_total; out_base = out_total;
        src_limit = offered + 100000;
        flushed = 1'b0;
        for (int c = 0; c < 40000 && !flushed; c++) begin
            drive_cycle();
            if ((acc_total - acc_base) >= 2 * N && fft_cnt == 10'd300) begin
                flush = 1'b1;
                flushed = 1'b1;
            end
        end
        check_eq("C_flush_issued", int'(flushed), 1);
        run_until_idle(40000, "C_drain_timeout");
        stop_on_flush = 1'b0;
        s_valid = 1'b0;
        check_eq("C_accepted", acc_total - acc_base, 3 * N);
        check_eq("C_outputs", out_total - out_base, 3 * N);
        check_eq("C_frame_cnt", int'(frame_cnt), 5);

        // Reset in the middle of a drain, then a clean frame.
        vpct = 100; rpct = 100;
        acc_base = acc_total;
        src_limit = offered + N;
        wait_accept(acc_base + N, 3000, "E_accept_timeout");
        drive_cycle();
        flush = 1'b1;
        for (int c = 0; c < 3000 && flush_adv < 200; c++) drive_cycle();
        check_eq("E_flush_reached", int'(flush_adv >= 200), 1);
        @(posedge clk);
        #2;
        s_valid = 1'b1; m_ready = 1'b1; rst = 1'b0;
        #1;
        check_eq("E_rst_busy", int'(busy), 0);
        check_eq("E_rst_fft_enable", int'(fft_enable), 0);
        check_eq("E_rst_m_valid", int'(m_valid), 0);
        check_eq("E_rst_s_ready", int'(s_ready), 1);
        check_eq("E_rst_fft_cnt", int'(fft_cnt), 0);
        check_eq("E_rst_frame_cnt", int'(frame_cnt), 0);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        rst = 1'b1;
        acc_base = acc_total; out_base = out_total;
        src_limit = offered + N;
        wait_accept(acc_base + N, 3000, "E2_accept_timeout");
        drive_cycle();
        flush = 1'b1;
        run_until_idle(5000, "E2_drain_timeout");
        check_eq("E2_outputs", out_total - out_base, N);
        check_eq("E2_frame_cnt", int'(frame_cnt), 1);
        check_eq("E2_busy", int'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
